// File: rtl/bus_pkg.sv
// Shared types and address map for the CPU-side bus decoder.
// Region decode is a pure function of the 16-bit CPU address.
package bus_pkg;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_PPU,
        REGION_ROM,
        REGION_OPEN
    } region_e;

    typedef enum logic [2:0] {
        IDLE,
        RAM_READ,
        PPU_READ,
        ROM_WAIT,
        DONE
    } state_e;

    localparam logic [15:0] RAM_LIMIT = 16'h1FFF;
    localparam logic [15:0] PPU_BASE  = 16'h2000;
    localparam logic [15:0] PPU_LIMIT = 16'h3FFF;
    localparam logic [15:0] ROM_BASE  = 16'h8000;

    // RAM starts at address zero, so only its upper limit needs checking.
    function automatic region_e decode_region(input logic [15:0] address);
        if (address <= RAM_LIMIT) begin
            return REGION_RAM;
        end else if (address >= PPU_BASE && address <= PPU_LIMIT) begin
            return REGION_PPU;
        end else if (address >= ROM_BASE) begin
            return REGION_ROM;
        end else begin
            return REGION_OPEN;
        end
    endfunction

endpackage

// File: rtl/work_ram.sv
// Single-port synchronous work RAM, 8 bits wide, one-cycle read latency.
// Reads return the old contents when the same address is written in that cycle.
module work_ram #(
    parameter int ADDRESS_WIDTH = 11
) (
    input  logic                     clock_i,
    input  logic                     write_enable_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [7:0]               write_data_i,
    output logic [7:0]               read_data_o
);

    logic [7:0] mem [2**ADDRESS_WIDTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; callers
    // must gate write_enable_i themselves while reset is asserted.
    always_ff @(posedge clock_i) begin
        if (write_enable_i) begin
            mem[address_i] <= write_data_i;
        end
        read_data_o <= mem[address_i];
    end

endmodule

// File: rtl/cpu_bus.sv
// CPU bus decoder/responder: routes each access to work RAM, PPU registers or
// PRG ROM and holds cpu_data_valid_o low until the selected target answers.
module cpu_bus
    import bus_pkg::*;
#(
    parameter int RAM_ADDRESS_WIDTH = 11,
    parameter int ROM_TIMEOUT       = 8
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cpu_strobe_i,
    input  logic [15:0] cpu_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_data_valid_o,
    output logic [14:0] rom_address_o,
    output logic        rom_request_o,
    input  logic        rom_ready_i,
    input  logic [7:0]  rom_data_i,
    output logic [2:0]  ppu_address_o,
    output logic        ppu_read_o,
    output logic        ppu_write_o,
    output logic [7:0]  ppu_data_o,
    input  logic [7:0]  ppu_data_i,
    output logic        rom_timeout_o
);

    state_e     state;
    region_e    region;
    logic       strobe_q;
    logic       restart_q;
    logic       abort;
    logic       access_start;
    logic       is_write;
    logic       ram_write;
    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_next;
    logic       wait_expired;
    logic [7:0] ram_read_data;

    assign region   = decode_region(cpu_address_i);
    assign is_write = cpu_write_i;

    // A new strobe while the ROM is still busy first spends one cycle with the
    // request dropped; restart_q then replays the start for the held address.
    assign abort        = strobe_q && (state == ROM_WAIT) && !reset_i;
    assign access_start = (strobe_q || restart_q) && !abort && !reset_i;

    assign ram_write   = access_start && (region == REGION_RAM) && is_write;
    assign ppu_read_o  = access_start && (region == REGION_PPU) && !is_write && cpu_read_i;
    assign ppu_write_o = access_start && (region == REGION_PPU) && is_write;
    assign ppu_data_o  = ppu_write_o ? cpu_data_i : 8'h00;

    assign rom_address_o = cpu_address_i[14:0];
    assign ppu_address_o = cpu_address_i[2:0];

    assign wait_cnt_next = (wait_cnt == 4'hF) ? wait_cnt : wait_cnt + 4'd1;
    assign wait_expired  = wait_cnt_next >= 4'(ROM_TIMEOUT);

    work_ram #(
        .ADDRESS_WIDTH (RAM_ADDRESS_WIDTH)
    ) u_work_ram (
        .clock_i        (clock_i),
        .write_enable_i (ram_write),
        .address_i      (cpu_address_i[RAM_ADDRESS_WIDTH-1:0]),
        .write_data_i   (cpu_data_i),
        .read_data_o    (ram_read_data)
    );

    // NOTE: all state below uses non-blocking assignments so every branch
    // sees the pre-edge values of state, wait_cnt and cpu_data_o.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            strobe_q         <= 1'b1;
            restart_q        <= 1'b0;
            state            <= IDLE;
            wait_cnt         <= 4'd0;
            cpu_data_o       <= 8'h00;
            cpu_data_valid_o <= 1'b0;
            rom_request_o    <= 1'b0;
            rom_timeout_o    <= 1'b0;
        end else begin
            strobe_q  <= cpu_strobe_i;
            restart_q <= abort;
            if (abort) begin
                state            <= IDLE;
                cpu_data_valid_o <= 1'b0;
                rom_request_o    <= 1'b0;
            end else if (access_start) begin
                cpu_data_valid_o <= 1'b0;
                wait_cnt         <= 4'd0;
                rom_request_o    <= 1'b0;
                if (is_write) begin
                    cpu_data_o <= cpu_data_i;
                    state      <= DONE;
                end else begin
                    case (region)
                        REGION_RAM: state <= RAM_READ;
                        REGION_PPU: state <= cpu_read_i ? PPU_READ : DONE;
                        REGION_ROM: begin
                            state         <= ROM_WAIT;
                            rom_request_o <= 1'b1;
                        end
                        default:    state <= DONE;
                    endcase
                end
            end else begin
                case (state)
                    RAM_READ: begin
                        cpu_data_o       <= ram_read_data;
                        cpu_data_valid_o <= 1'b1;
                        state            <= DONE;
                    end
                    PPU_READ: begin
                        cpu_data_o       <= ppu_data_i;
                        cpu_data_valid_o <= 1'b1;
                        state            <= DONE;
                    end
                    ROM_WAIT: begin
                        wait_cnt <= wait_cnt_next;
                        if (rom_ready_i) begin
                            cpu_data_o    <= rom_data_i;
                            rom_request_o <= 1'b0;
                            state         <= DONE;
                        end else if (wait_expired) begin
                            rom_timeout_o <= 1'b1;
                            rom_request_o <= 1'b0;
                            state         <= DONE;
                        end
                    end
                    DONE:    cpu_data_valid_o <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus.sv
// Directed bench for cpu_bus: RAM mirror, ROM wait/timeout/abort, PPU
// register pulses, open bus and asynchronous reset mid-access.
module tb_cpu_bus;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cpu_strobe_i = 1'b0;
    logic [15:0] cpu_address_i = 16'h5000;
    logic [7:0]  cpu_data_i = 8'h00;
    logic        cpu_read_i = 1'b1;
    logic        cpu_write_i = 1'b0;
    logic [7:0]  cpu_data_o;
    logic        cpu_data_valid_o;
    logic [14:0] rom_address_o;
    logic        rom_request_o;
    logic        rom_ready_i = 1'b0;
    logic [7:0]  rom_data_i = 8'h00;
    logic [2:0]  ppu_address_o;
    logic        ppu_read_o;
    logic        ppu_write_o;
    logic [7:0]  ppu_data_o;
    logic [7:0]  ppu_data_i = 8'h00;
    logic        rom_timeout_o;

    int total = 0;
    int bad   = 0;

    cpu_bus dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .cpu_strobe_i     (cpu_strobe_i),
        .cpu_address_i    (cpu_address_i),
        .cpu_data_i       (cpu_data_i),
        .cpu_read_i       (cpu_read_i),
        .cpu_write_i      (cpu_write_i),
        .cpu_data_o       (cpu_data_o),
        .cpu_data_valid_o (cpu_data_valid_o),
        .rom_address_o    (rom_address_o),
        .rom_request_o    (rom_request_o),
        .rom_ready_i      (rom_ready_i),
        .rom_data_i       (rom_data_i),
        .ppu_address_o    (ppu_address_o),
        .ppu_read_o       (ppu_read_o),
        .ppu_write_o      (ppu_write_o),
        .ppu_data_o       (ppu_data_o),
        .ppu_data_i       (ppu_data_i),
        .rom_timeout_o    (rom_timeout_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    // Strobe for one cycle; returns positioned in the start cycle (cycle 0).
    task automatic strobe(input logic [15:0] address, input logic [7:0] data,
                          input logic rd, input logic wr);
        cpu_strobe_i  = 1'b1;
        cpu_address_i = address;
        cpu_data_i    = data;
        cpu_read_i    = rd;
        cpu_write_i   = wr;
        tick();
        cpu_strobe_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clock_i);
        #1;
        check("rst_data", cpu_data_o, 8'h00);
        check("rst_valid", cpu_data_valid_o, 1'b0);
        check("rst_req", rom_request_o, 1'b0);
        check("rst_ppu_rd", ppu_read_o, 1'b0);
        check("rst_ppu_wr", ppu_write_o, 1'b0);
        check("rst_ppu_data", ppu_data_o, 8'h00);
        check("rst_timeout", rom_timeout_o, 1'b0);

        // First cycle after release is a start: open read of 0x5000
        reset_i = 1'b0;
        tick();
        check("boot_valid_c1", cpu_data_valid_o, 1'b0);
        tick();
        check("boot_valid_c2", cpu_data_valid_o, 1'b1);

        // RAM write 0x3C -> 0x0005, then 0x77 -> 0x0006
        strobe(16'h0005, 8'h3C, 1'b0, 1'b1);
        check("ramwr_ppu_wr", ppu_write_o, 1'b0);
        tick();
        check("ramwr_valid_c1", cpu_data_valid_o, 1'b0);
        check("ramwr_bus", cpu_data_o, 8'h3C);
        tick();
        check("ramwr_valid_c2", cpu_data_valid_o, 1'b1);
        strobe(16'h0006, 8'h77, 1'b0, 1'b1);
        tick();
        tick();
        check("ramwr2_bus", cpu_data_o, 8'h77);

        // Mirror read of 0x0805 returns 0x3C
        strobe(16'h0805, 8'h00, 1'b1, 1'b0);
        tick();
        check("mirror_valid_c1", cpu_data_valid_o, 1'b0);
        tick();
        check("mirror_valid_c2", cpu_data_valid_o, 1'b1);
        check("mirror_data", cpu_data_o, 8'h3C);

        // ROM read 0xFFFC, ready 3 cycles after start, data 0x00
        strobe(16'hFFFC, 8'h00, 1'b1, 1'b0);
        check("rom_addr", rom_address_o, 15'h7FFC);
        tick();
        check("rom_req_c1", rom_request_o, 1'b1);
        tick();
        tick();
        rom_ready_i = 1'b1;
        rom_data_i  = 8'h00;
        tick();
        rom_ready_i = 1'b0;
        check("rom_valid_c4", cpu_data_valid_o, 1'b0);
        check("rom_req_c4", rom_request_o, 1'b0);
        tick();
        check("rom_valid_c5", cpu_data_valid_o, 1'b1);
        check("rom_data_fffc", cpu_data_o, 8'h00);

        // ROM read 0xFFFD, ready 1 cycle after start, data 0x80
        strobe(16'hFFFD, 8'h00, 1'b1, 1'b0);
        tick();
        rom_ready_i = 1'b1;
        rom_data_i  = 8'h80;
        tick();
        rom_ready_i = 1'b0;
        check("rom2_valid_c2", cpu_data_valid_o, 1'b0);
        tick();
        check("rom2_valid_c3", cpu_data_valid_o, 1'b1);
        check("rom2_data", cpu_data_o, 8'h80);

        // PPU read 0x3FFA with ppu_data_i = 0xA0
        strobe(16'h3FFA, 8'h00, 1'b1, 1'b0);
        check("ppurd_index", ppu_address_o, 3'd2);
        check("ppurd_pulse_c0", ppu_read_o, 1'b1);
        ppu_data_i = 8'hA0;
        tick();
        check("ppurd_pulse_c1", ppu_read_o, 1'b0);
        tick();
        check("ppurd_valid", cpu_data_valid_o, 1'b1);
        check("ppurd_data", cpu_data_o, 8'hA0);

        // PPU write 0x55 -> 0x2006
        strobe(16'h2006, 8'h55, 1'b0, 1'b1);
        check("ppuwr_pulse_c0", ppu_write_o, 1'b1);
        check("ppuwr_data", ppu_data_o, 8'h55);
        check("ppuwr_index", ppu_address_o, 3'd6);
        check("ppuwr_no_rd", ppu_read_o, 1'b0);
        tick();
        check("ppuwr_pulse_c1", ppu_write_o, 1'b0);
        tick();
        check("ppuwr_valid", cpu_data_valid_o, 1'b1);

        // Open-bus read of 0x5000 returns the last driven value
        strobe(16'h5000, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        check("open_valid", cpu_data_valid_o, 1'b1);
        check("open_data", cpu_data_o, 8'h55);

        // ROM timeout: ready never arrives
        strobe(16'h8123, 8'h00, 1'b1, 1'b0);
        repeat (8) tick();
        check("to_req_c8", rom_request_o, 1'b1);
        check("to_flag_c8", rom_timeout_o, 1'b0);
        tick();
        check("to_req_c9", rom_request_o, 1'b0);
        check("to_valid_c9", cpu_data_valid_o, 1'b0);
        check("to_flag_c9", rom_timeout_o, 1'b1);
        tick();
        check("to_valid_c10", cpu_data_valid_o, 1'b1);
        check("to_data", cpu_data_o, 8'h55);

        // Strobe during ROM_WAIT: request drops one cycle, then restarts
        strobe(16'hFFFC, 8'h00, 1'b1, 1'b0);
        tick();
        tick();
        strobe(16'hFFFD, 8'h00, 1'b1, 1'b0);
        check("abort_req_c4", rom_request_o, 1'b1);
        tick();
        check("abort_req_c5", rom_request_o, 1'b0);
        tick();
        check("abort_req_c6", rom_request_o, 1'b1);
        check("abort_valid_c6", cpu_data_valid_o, 1'b0);
        tick();

        // Asynchronous reset while in ROM_WAIT
        reset_i       = 1'b1;
        cpu_address_i = 16'hFFFC;
        #1;
        check("arst_req", rom_request_o, 1'b0);
        check("arst_valid", cpu_data_valid_o, 1'b0);
        check("arst_data", cpu_data_o, 8'h00);
        check("arst_timeout", rom_timeout_o, 1'b0);
        tick();
        tick();
        reset_i = 1'b0;
        tick();
        check("post_req", rom_request_o, 1'b1);
        check("post_addr", rom_address_o, 15'h7FFC);
        rom_ready_i = 1'b1;
        rom_data_i  = 8'h80;
        tick();
        rom_ready_i = 1'b0;
        tick();
        check("post_valid", cpu_data_valid_o, 1'b1);
        check("post_data", cpu_data_o, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_bus.md
# cpu_bus

CPU-side bus decoder and responder that consumes the CPU core's `address_o`/`data_o`/`bus_read_o`/`bus_write_o` and produces its `data_i`/`data_valid_i`. It sits directly below the CPU and routes each access to internal work RAM, the PPU register window or the external PRG ROM port. It returns open-bus data for unmapped reads. It holds `cpu_data_valid_o` low until the selected target has answered, so the CPU's stage machine stalls on slow targets.

## Interface
Parameters:
- `RAM_ADDRESS_WIDTH`, default 11. Work RAM is 2 KiB, mirrored across 0x0000–0x1FFF.
- `ROM_TIMEOUT`, default 8. Maximum number of cycles to wait for `rom_ready_i`.

Ports (one clock; reset is asynchronous and active-high):
- `clock_i` in 1: system clock, the same clock as the CPU.
- `reset_i` in 1: asynchronous, active-high reset.
- `cpu_strobe_i` in 1: the CPU `clock_ready_o` pulse. The CPU bus outputs change on the edge where this is high.
- `cpu_address_i` in 16: CPU `address_o`.
- `cpu_data_i` in 8: CPU `data_o` (write data).
- `cpu_read_i` in 1: CPU `bus_read_o`.
- `cpu_write_i` in 1: CPU `bus_write_o`.
- `cpu_data_o` out 8: read data to the CPU `data_i`.
- `cpu_data_valid_o` out 1: to the CPU `data_valid_i`.
- `rom_address_o` out 15: PRG ROM byte address, equal to `cpu_address_i[14:0]`.
- `rom_request_o` out 1: ROM read request, level-held until ready.
- `rom_ready_i` in 1: ROM data valid this cycle.
- `rom_data_i` in 8: ROM read data.
- `ppu_address_o` out 3: PPU register index, equal to `cpu_address_i[2:0]`.
- `ppu_read_o` out 1: one-cycle PPU register read pulse.
- `ppu_write_o` out 1: one-cycle PPU register write pulse.
- `ppu_data_o` out 8: PPU write data.
- `ppu_data_i` in 8: PPU read data, valid the cycle after `ppu_read_o`.
- `rom_timeout_o` out 1: sticky flag, set on any ROM timeout and cleared only by reset.

## Operation
- **Access start (`start`):** occurs on the first cycle after reset deassertion, and on the cycle after any cycle where `cpu_strobe_i` = 1 (registered strobe).
- **Access type:** the access is a write if `cpu_write_i` = 1, otherwise a read.
- **Read side effects:** PPU read side effects occur only when `cpu_read_i` = 1.
- **Decode at start, from `cpu_address_i`:**
  - 0x0000–0x1FFF → RAM; index = `address[RAM_ADDRESS_WIDTH-1:0]`.
  - 0x2000–0x3FFF → PPU; index = `address[2:0]`.
  - 0x8000–0xFFFF → ROM.
  - Anything else → OPEN.
- **FSM states:** IDLE, RAM_READ, PPU_READ, ROM_WAIT, DONE.
  - On `start` from any state: `cpu_data_valid_o` goes to 0, then the FSM branches by target and type.
  - RAM read → RAM_READ. Read data is registered from the synchronous RAM one cycle later → DONE.
  - RAM write → RAM written in the start cycle → DONE.
  - PPU read → `ppu_read_o` pulses in the start cycle → PPU_READ captures `ppu_data_i` → DONE.
  - PPU write → `ppu_write_o` pulses in the start cycle with `ppu_data_o` = `cpu_data_i` → DONE.
  - ROM read → ROM_WAIT with `rom_request_o` = 1. Leave when `rom_ready_i` = 1 (capture `rom_data_i`), or when the wait counter reaches `ROM_TIMEOUT` (keep last data, set `rom_timeout_o`) → DONE.
  - ROM write or OPEN write → ignored → DONE.
  - OPEN read → DONE with the last data value unchanged (open bus).
- **DONE:** `cpu_data_valid_o` = 1 and `cpu_data_o` is held until the next `start`.
- **Open-bus register:** `cpu_data_o` always holds the last value driven on the bus. A write updates it to `cpu_data_i`.
- **`start` during ROM_WAIT** (ROM slower than the CPU strobe period): abort the current access, drop `rom_request_o` for one cycle, then begin the new access.

## Timing
- **Reset values:** `cpu_data_o` = 0, `cpu_data_valid_o` = 0, `rom_request_o` = 0, `ppu_read_o` = 0, `ppu_write_o` = 0, `rom_timeout_o` = 0, `ppu_data_o` = 0, state IDLE, counter 0.
- **Asserting reset mid-access:** all outputs return to reset values immediately (asynchronous). No RAM write occurs after reset assertion.
- **Latency from `start` to valid:**
  - RAM, PPU, write, OPEN: 2 cycles.
  - ROM: k + 2, where `rom_ready_i` is first seen k cycles after `start`.
  - ROM timeout: `ROM_TIMEOUT` + 2.
- With `CLOCK_DIVIDER` = 12, every non-ROM access completes well before the next strobe.
- **Wait counter:** 4 bits, cleared at `start`, saturating.

## Structure
- **Package `bus_pkg`:** region enum (`REGION_RAM`, `REGION_PPU`, `REGION_ROM`, `REGION_OPEN`), the FSM state enum, the region base/limit constants, and a `decode_region` function.
- **Sub-module `work_ram`:** single-port synchronous RAM, 2^`RAM_ADDRESS_WIDTH` × 8, with one-cycle read latency and write-enable.

## Test plan
- Write 0x3C to 0x0005, then read 0x0805 → `cpu_data_o` = 0x3C (mirror), valid 2 cycles after `start`.
- Read 0xFFFC with `rom_ready_i` asserted 3 cycles after request, `rom_data_i` = 0x00 → `rom_address_o` = 0x7FFC, valid at `start`+5, data 0x00. Then read 0xFFFD → 0x80.
- Read 0x3FFA → `ppu_address_o` = 2, one `ppu_read_o` pulse. With `ppu_data_i` = 0xA0, `cpu_data_o` = 0xA0.
- Write 0x55 to 0x2006 → single `ppu_write_o` pulse, `ppu_data_o` = 0x55. A following read of 0x5000 returns 0x55 (open bus).
- Read ROM with `rom_ready_i` held 0 → valid at `start`+10, data unchanged, `rom_timeout_o` = 1.
- Assert `reset_i` during ROM_WAIT → `rom_request_o` = 0 and `cpu_data_valid_o` = 0 before the next edge. After release, a new access starts at 0xFFFC.
